// File: rtl/fir_host_pkg.sv
// Shared definitions for the FIR host: AXI-Lite FSM states, FIR register map
// offsets and ap_ctrl bit positions.
package fir_host_pkg;

    typedef enum logic [2:0] {
        AXIL_IDLE,
        AXIL_WRITE,
        AXIL_READ_A,
        AXIL_READ_D,
        AXIL_RESP
    } axil_state_e;

    localparam logic [11:0] ADDR_AP_CTRL  = 12'h000;
    localparam logic [11:0] ADDR_DATA_LEN = 12'h010;
    localparam logic [11:0] ADDR_TAP_BASE = 12'h040;

    localparam int unsigned AP_START    = 0;
    localparam int unsigned AP_DONE     = 1;
    localparam int unsigned AP_IDLE     = 2;
    localparam int unsigned AP_SS_READY = 4;
    localparam int unsigned AP_SM_READY = 5;

endpackage

// File: rtl/fir_host_fifo.sv
// Synchronous FIFO with wrap-bit pointers; head is presented combinationally.
// A push while full is refused even if a pop happens in the same cycle.
module fir_host_fifo #(
    parameter int unsigned WIDTH = 33,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             full_o,
    input  logic             pop_i,
    output logic             empty_o,
    output logic [WIDTH-1:0] head_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, rd_ptr_q;
    logic             push_ok, pop_ok;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;
    assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (clr_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q[AW-1:0]] <= data_i;
                wr_ptr_q                <= wr_ptr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/fir_axi_host.sv
// Host-side FIR interface: AXI-Lite register master, X[n] stream source, Y[n] sink.
// Define AXIL_TIMEOUT_EN to enable the AXI-Lite watchdog (rsp_err on expiry).
module fir_axi_host
    import fir_host_pkg::*;
#(
    parameter int unsigned pADDR_WIDTH    = 12,
    parameter int unsigned pDATA_WIDTH    = 32,
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                   axis_clk,
    input  logic                   axis_rst_n,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic                   cmd_write,
    input  logic [pADDR_WIDTH-1:0] cmd_addr,
    input  logic [pDATA_WIDTH-1:0] cmd_wdata,
    output logic                   rsp_valid,
    output logic [pDATA_WIDTH-1:0] rsp_rdata,
    output logic                   rsp_err,
    output logic                   awvalid,
    input  logic                   awready,
    output logic [pADDR_WIDTH-1:0] awaddr,
    output logic                   wvalid,
    input  logic                   wready,
    output logic [pDATA_WIDTH-1:0] wdata,
    output logic                   arvalid,
    input  logic                   arready,
    output logic [pADDR_WIDTH-1:0] araddr,
    input  logic                   rvalid,
    output logic                   rready,
    input  logic [pDATA_WIDTH-1:0] rdata,
    input  logic                   tx_valid,
    output logic                   tx_ready,
    input  logic [pDATA_WIDTH-1:0] tx_data,
    input  logic                   tx_last,
    output logic                   ss_tvalid,
    input  logic                   ss_tready,
    output logic [pDATA_WIDTH-1:0] ss_tdata,
    output logic                   ss_tlast,
    input  logic                   sm_tvalid,
    output logic                   sm_tready,
    input  logic [pDATA_WIDTH-1:0] sm_tdata,
    input  logic                   sm_tlast,
    output logic                   rx_valid,
    input  logic                   rx_ready,
    output logic [pDATA_WIDTH-1:0] rx_data,
    output logic                   rx_last,
    output logic [31:0]            rx_count,
    output logic                   done_seen,
    input  logic                   stream_clr
);

    axil_state_e            state_q, state_d;
    logic [pADDR_WIDTH-1:0] addr_q, addr_d;
    logic [pDATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [pDATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                   aw_done_q, aw_done_d;
    logic                   w_done_q, w_done_d;

`ifdef AXIL_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_q, tmo_d;
    logic          err_q, err_d;
`endif

    assign awaddr    = addr_q;
    assign araddr    = addr_q;
    assign wdata     = wdata_q;
    assign rsp_rdata = rdata_q;

    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            state_q   <= AXIL_IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        cmd_ready = 1'b0;
        awvalid   = 1'b0;
        wvalid    = 1'b0;
        arvalid   = 1'b0;
        rready    = 1'b0;
        rsp_valid = 1'b0;
        case (state_q)
            AXIL_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    addr_d    = cmd_addr;
                    wdata_d   = cmd_wdata;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = cmd_write ? AXIL_WRITE : AXIL_READ_A;
                end
            end
            AXIL_WRITE: begin
                // AW and W complete independently; each valid drops once its own handshake is done
                awvalid = !aw_done_q;
                wvalid  = !w_done_q;
                if (awvalid && awready) aw_done_d = 1'b1;
                if (wvalid && wready)   w_done_d  = 1'b1;
                if (aw_done_d && w_done_d) state_d = AXIL_RESP;
            end
            AXIL_READ_A: begin
                arvalid = 1'b1;
                if (arready) state_d = AXIL_READ_D;
            end
            AXIL_READ_D: begin
                rready = 1'b1;
                if (rvalid) begin
                    rdata_d = rdata;
                    state_d = AXIL_RESP;
                end
            end
            AXIL_RESP: begin
                rsp_valid = 1'b1;
                state_d   = AXIL_IDLE;
            end
            default: state_d = AXIL_IDLE;
        endcase

`ifdef AXIL_TIMEOUT_EN
        tmo_d = '0;
        err_d = err_q;
        if (state_q == AXIL_IDLE && cmd_valid) err_d = 1'b0;
        if (state_q == AXIL_WRITE || state_q == AXIL_READ_A || state_q == AXIL_READ_D) begin
            tmo_d = tmo_q + 1'b1;
            if (tmo_q == TW'(TIMEOUT_CYCLES - 1) && state_d != AXIL_RESP) begin
                state_d = AXIL_RESP;
                err_d   = 1'b1;
                if (state_q != AXIL_WRITE) rdata_d = '0;
            end
        end
`endif
    end

`ifdef AXIL_TIMEOUT_EN
    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            tmo_q <= '0;
            err_q <= 1'b0;
        end else begin
            tmo_q <= tmo_d;
            err_q <= err_d;
        end
    end
    assign rsp_err = err_q;
`else
    assign rsp_err = 1'b0;
`endif

    logic                 tx_full, tx_empty;
    logic [pDATA_WIDTH:0] tx_head;

    fir_host_fifo #(
        .WIDTH (pDATA_WIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .clk_i   (axis_clk),
        .rst_ni  (axis_rst_n),
        .clr_i   (stream_clr),
        .push_i  (tx_valid),
        .data_i  ({tx_last, tx_data}),
        .full_o  (tx_full),
        .pop_i   (ss_tready),
        .empty_o (tx_empty),
        .head_o  (tx_head)
    );

    assign tx_ready  = !tx_full;
    assign ss_tvalid = !tx_empty;
    assign ss_tdata  = tx_head[pDATA_WIDTH-1:0];
    assign ss_tlast  = tx_head[pDATA_WIDTH];

    logic                   rx_valid_q, rx_last_q, done_q;
    logic [pDATA_WIDTH-1:0] rx_data_q;
    logic [31:0]            rx_count_q;
    logic                   sm_hs;

    assign sm_tready = !rx_valid_q || rx_ready;
    assign sm_hs     = sm_tvalid && sm_tready;
    assign rx_valid  = rx_valid_q;
    assign rx_data   = rx_data_q;
    assign rx_last   = rx_last_q;
    assign rx_count  = rx_count_q;
    assign done_seen = done_q;

    // stream_clr outranks any handshake landing in the same cycle
    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            rx_valid_q <= 1'b0;
            rx_data_q  <= '0;
            rx_last_q  <= 1'b0;
            rx_count_q <= '0;
            done_q     <= 1'b0;
        end else if (stream_clr) begin
            rx_valid_q <= 1'b0;
            rx_count_q <= '0;
            done_q     <= 1'b0;
        end else begin
            if (sm_hs) begin
                rx_valid_q <= 1'b1;
                rx_data_q  <= sm_tdata;
                rx_last_q  <= sm_tlast;
                rx_count_q <= rx_count_q + 32'd1;
                if (sm_tlast) done_q <= 1'b1;
            end else if (rx_ready) begin
                rx_valid_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fir_axi_host.sv
// Directed self-checking bench for fir_axi_host (AXI-Lite master, TX FIFO, RX buffer).
module tb_fir_axi_host;
    import fir_host_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 0, cmd_ready, cmd_write = 0;
    logic [11:0] cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic        awvalid, awready = 0, wvalid, wready = 0, arvalid, arready = 0;
    logic        rvalid = 0, rready;
    logic [11:0] awaddr, araddr;
    logic [31:0] wdata, rdata = '0;
    logic        tx_valid = 0, tx_ready, tx_last = 0;
    logic [31:0] tx_data = '0;
    logic        ss_tvalid, ss_tready = 0, ss_tlast;
    logic [31:0] ss_tdata;
    logic        sm_tvalid = 0, sm_tready, sm_tlast = 0;
    logic [31:0] sm_tdata = '0;
    logic        rx_valid, rx_ready = 0, rx_last;
    logic [31:0] rx_data, rx_count;
    logic        done_seen, stream_clr = 0;

    int pass_cnt = 0;
    int total_cnt = 0;

    fir_axi_host #(
        .pADDR_WIDTH    (12),
        .pDATA_WIDTH    (32),
        .FIFO_DEPTH     (4),
        .TIMEOUT_CYCLES (64)
    ) dut (
        .axis_clk (clk), .axis_rst_n (rst_n),
        .cmd_valid (cmd_valid), .cmd_ready (cmd_ready), .cmd_write (cmd_write),
        .cmd_addr (cmd_addr), .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid), .rsp_rdata (rsp_rdata), .rsp_err (rsp_err),
        .awvalid (awvalid), .awready (awready), .awaddr (awaddr),
        .wvalid (wvalid), .wready (wready), .wdata (wdata),
        .arvalid (arvalid), .arready (arready), .araddr (araddr),
        .rvalid (rvalid), .rready (rready), .rdata (rdata),
        .tx_valid (tx_valid), .tx_ready (tx_ready), .tx_data (tx_data), .tx_last (tx_last),
        .ss_tvalid (ss_tvalid), .ss_tready (ss_tready), .ss_tdata (ss_tdata), .ss_tlast (ss_tlast),
        .sm_tvalid (sm_tvalid), .sm_tready (sm_tready), .sm_tdata (sm_tdata), .sm_tlast (sm_tlast),
        .rx_valid (rx_valid), .rx_ready (rx_ready), .rx_data (rx_data), .rx_last (rx_last),
        .rx_count (rx_count), .done_seen (done_seen), .stream_clr (stream_clr)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        @(negedge clk);
        total_cnt++;
        if ({cmd_ready, rsp_valid, rsp_err, awvalid, wvalid, arvalid, rready,
             ss_tvalid, rx_valid, done_seen} !== 10'b10_0000_0000)
            $display("FAIL reset_flags: got %b want %b",
                     {cmd_ready, rsp_valid, rsp_err, awvalid, wvalid, arvalid, rready,
                      ss_tvalid, rx_valid, done_seen}, 10'b10_0000_0000);
        else pass_cnt++;
        total_cnt++;
        if ({rx_count, rsp_rdata} !== 64'd0)
            $display("FAIL reset_values: rx_count=%0d rsp_rdata=%h want 0", rx_count, rsp_rdata);
        else pass_cnt++;
        @(posedge clk);
        #3 rst_n = 1'b1;
        next_cycle();
    endtask

    // aw_c / w_c: cycle (counting from first WRITE cycle = 1) in which the slave raises its ready
    task automatic test_write(input logic [11:0] a, input logic [31:0] d,
                              input int aw_c, input int w_c);
        int rsp_c;
        rsp_c = ((aw_c > w_c) ? aw_c : w_c) + 1;
        cmd_valid = 1; cmd_write = 1; cmd_addr = a; cmd_wdata = d;
        @(negedge clk);
        total_cnt++;
        if (cmd_ready !== 1'b1) $display("FAIL write_cmd_ready: got %b want 1", cmd_ready);
        else pass_cnt++;
        for (int c = 1; c <= rsp_c + 1; c++) begin
            next_cycle();
            cmd_valid = 0;
            awready = (c == aw_c);
            wready  = (c == w_c);
            @(negedge clk);
            total_cnt++;
            if ({awvalid, wvalid, rsp_valid, cmd_ready} !==
                {c <= aw_c, c <= w_c, c == rsp_c, c > rsp_c})
                $display("FAIL write_seq a=%h c=%0d: aw/w/rsp/rdy got %b want %b", a, c,
                         {awvalid, wvalid, rsp_valid, cmd_ready},
                         {c <= aw_c, c <= w_c, c == rsp_c, c > rsp_c});
            else pass_cnt++;
            if (awvalid) begin
                total_cnt++;
                if (awaddr !== a) $display("FAIL write_awaddr c=%0d: got %h want %h", c, awaddr, a);
                else pass_cnt++;
            end
            if (wvalid) begin
                total_cnt++;
                if (wdata !== d) $display("FAIL write_wdata c=%0d: got %0d want %0d", c, wdata, d);
                else pass_cnt++;
            end
            if (rsp_valid) begin
                total_cnt++;
                if (rsp_err !== 1'b0) $display("FAIL write_rsp_err: got %b want 0", rsp_err);
                else pass_cnt++;
            end
        end
        next_cycle();
        awready = 0; wready = 0;
    endtask

    task automatic test_read;
        logic [31:0] rd_val;
        rd_val = 32'h0;
        rd_val[AP_IDLE] = 1'b1;
        cmd_valid = 1; cmd_write = 0; cmd_addr = ADDR_AP_CTRL; cmd_wdata = '0;
        for (int c = 1; c <= 6; c++) begin
            next_cycle();
            cmd_valid = 0;
            arready = (c == 2);
            rvalid  = (c == 4);
            rdata   = (c == 4) ? rd_val : 32'hDEAD_BEEF;
            @(negedge clk);
            total_cnt++;
            if ({arvalid, rready, rsp_valid} !== {c == 1 || c == 2, c == 3 || c == 4, c == 5})
                $display("FAIL read_seq c=%0d: ar/rready/rsp got %b want %b", c,
                         {arvalid, rready, rsp_valid}, {c == 1 || c == 2, c == 3 || c == 4, c == 5});
            else pass_cnt++;
            if (arvalid) begin
                total_cnt++;
                if (araddr !== ADDR_AP_CTRL) $display("FAIL read_araddr: got %h want 000", araddr);
                else pass_cnt++;
            end
            if (c == 5) begin
                total_cnt++;
                if (rsp_rdata !== 32'h4) $display("FAIL read_rdata: got %h want 00000004", rsp_rdata);
                else pass_cnt++;
            end
        end
        next_cycle();
        arready = 0; rvalid = 0;
    endtask

`ifdef AXIL_TIMEOUT_EN
    task automatic test_timeout;
        bit seen;
        seen = 0;
        cmd_valid = 1; cmd_write = 0; cmd_addr = ADDR_AP_CTRL; arready = 0;
        next_cycle();
        cmd_valid = 0;
        for (int c = 1; c <= 100 && !seen; c++) begin
            @(negedge clk);
            if (rsp_valid) begin
                seen = 1;
                total_cnt++;
                if (c != 65 || rsp_err !== 1'b1 || rsp_rdata !== 32'd0 || arvalid !== 1'b0)
                    $display("FAIL timeout_rsp: cycle=%0d err=%b rdata=%h arvalid=%b want 65/1/0/0",
                             c, rsp_err, rsp_rdata, arvalid);
                else pass_cnt++;
            end
            next_cycle();
        end
        if (!seen) begin
            total_cnt++;
            $display("FAIL timeout_rsp: no rsp_valid within 100 cycles, want at 65");
        end
        @(negedge clk);
        total_cnt++;
        if ({arvalid, cmd_ready} !== 2'b01) $display("FAIL timeout_after: ar/rdy got %b want 01", {arvalid, cmd_ready});
        else pass_cnt++;
        next_cycle();
    endtask
`endif

    task automatic test_mid_reset;
        cmd_valid = 1; cmd_write = 1; cmd_addr = ADDR_TAP_BASE; cmd_wdata = 32'h55;
        next_cycle();
        cmd_valid = 0;
        @(negedge clk);
        total_cnt++;
        if ({awvalid, wvalid} !== 2'b11) $display("FAIL midrst_pre: aw/w got %b want 11", {awvalid, wvalid});
        else pass_cnt++;
        #2 rst_n = 1'b0;
        #1;
        total_cnt++;
        if ({awvalid, wvalid, cmd_ready} !== 3'b001)
            $display("FAIL midrst_async: aw/w/rdy got %b want 001", {awvalid, wvalid, cmd_ready});
        else pass_cnt++;
        @(posedge clk);
        #3 rst_n = 1'b1;
        next_cycle();
    endtask

    task automatic test_tx_fifo;
        logic [31:0] got[$];
        logic        got_last[$];
        bit          push_hs;
        ss_tready = 0;
        for (int k = 1; k <= 5; k++) begin
            tx_valid = 1; tx_data = 32'(k); tx_last = (k == 5);
            @(negedge clk);
            total_cnt++;
            if ({tx_ready, ss_tvalid} !== {k <= 4, k >= 2})
                $display("FAIL tx_fill k=%0d: tx_ready/ss_tvalid got %b want %b", k,
                         {tx_ready, ss_tvalid}, {k <= 4, k >= 2});
            else pass_cnt++;
            next_cycle();
        end
        ss_tready = 1;
        for (int c = 0; c < 20 && got.size() < 5; c++) begin
            @(negedge clk);
            push_hs = tx_valid && tx_ready;
            if (c == 0) begin
                total_cnt++;
                if (tx_ready !== 1'b0) $display("FAIL tx_full_pop: tx_ready got %b want 0", tx_ready);
                else pass_cnt++;
            end
            if (ss_tvalid) begin
                got.push_back(ss_tdata);
                got_last.push_back(ss_tlast);
            end
            next_cycle();
            if (push_hs) tx_valid = 0;
        end
        ss_tready = 0;
        tx_valid = 0;
        total_cnt++;
        if (got.size() != 5) $display("FAIL tx_count: got %0d words want 5", got.size());
        else pass_cnt++;
        for (int i = 0; i < got.size(); i++) begin
            total_cnt++;
            if (got[i] !== 32'(i + 1) || got_last[i] !== (i == 4))
                $display("FAIL tx_order i=%0d: data=%0d last=%b want %0d/%b", i, got[i], got_last[i],
                         i + 1, i == 4);
            else pass_cnt++;
        end
        @(negedge clk);
        total_cnt++;
        if ({ss_tvalid, tx_ready} !== 2'b01) $display("FAIL tx_drained: ss_tvalid/tx_ready got %b want 01",
                                                     {ss_tvalid, tx_ready});
        else pass_cnt++;
        next_cycle();
    endtask

    task automatic test_rx;
        logic [31:0] words [3];
        logic [31:0] rcv[$];
        logic        rcv_last[$];
        int          sent;
        bit          sm_hs;
        words[0] = 32'hA1; words[1] = 32'hB2; words[2] = 32'hC3;
        sent = 0;
        for (int c = 0; c < 20 && rcv.size() < 3; c++) begin
            rx_ready  = (c != 1);
            sm_tvalid = (sent < 3);
            sm_tdata  = (sent < 3) ? words[sent] : 32'd0;
            sm_tlast  = (sent == 2);
            @(negedge clk);
            sm_hs = sm_tvalid && sm_tready;
            if (c == 1) begin
                total_cnt++;
                if (sm_tready !== 1'b0) $display("FAIL rx_backpressure: sm_tready got %b want 0", sm_tready);
                else pass_cnt++;
            end
            if (rx_valid && rx_ready) begin
                rcv.push_back(rx_data);
                rcv_last.push_back(rx_last);
            end
            next_cycle();
            if (sm_hs) sent++;
        end
        sm_tvalid = 0; sm_tlast = 0;
        total_cnt++;
        if (rcv.size() != 3) $display("FAIL rx_words: got %0d want 3", rcv.size());
        else pass_cnt++;
        for (int i = 0; i < rcv.size(); i++) begin
            total_cnt++;
            if (rcv[i] !== words[i] || rcv_last[i] !== (i == 2))
                $display("FAIL rx_data i=%0d: data=%h last=%b want %h/%b", i, rcv[i], rcv_last[i],
                         words[i], i == 2);
            else pass_cnt++;
        end
        @(negedge clk);
        total_cnt++;
        if (rx_count !== 32'd3 || done_seen !== 1'b1)
            $display("FAIL rx_status: rx_count=%0d done_seen=%b want 3/1", rx_count, done_seen);
        else pass_cnt++;
        next_cycle();
    endtask

    task automatic test_stream_clr;
        ss_tready = 0; rx_ready = 1;
        tx_valid = 1; tx_data = 32'd77; tx_last = 0;
        next_cycle();
        stream_clr = 1;
        tx_data = 32'd78;
        sm_tvalid = 1; sm_tdata = 32'h99; sm_tlast = 1;
        @(negedge clk);
        total_cnt++;
        if ({ss_tvalid, tx_ready, sm_tready} !== 3'b111 || rx_count !== 32'd3 || done_seen !== 1'b1)
            $display("FAIL clr_pre: vld/txrdy/smrdy=%b cnt=%0d done=%b want 111/3/1",
                     {ss_tvalid, tx_ready, sm_tready}, rx_count, done_seen);
        else pass_cnt++;
        next_cycle();
        stream_clr = 0; tx_valid = 0; sm_tvalid = 0; sm_tlast = 0;
        @(negedge clk);
        total_cnt++;
        if ({ss_tvalid, rx_valid, done_seen} !== 3'b000 || rx_count !== 32'd0)
            $display("FAIL clr_post: ss_tvalid/rx_valid/done=%b cnt=%0d want 000/0",
                     {ss_tvalid, rx_valid, done_seen}, rx_count);
        else pass_cnt++;
        next_cycle();
    endtask

    initial begin
        test_reset();
        test_write(ADDR_DATA_LEN, 32'd600, 2, 5);
        test_write(ADDR_TAP_BASE, 32'h1234, 1, 1);
        test_write(12'h044, 32'hFFFF_FFFE, 3, 1);
        test_read();
`ifdef AXIL_TIMEOUT_EN
        test_timeout();
`endif
        test_mid_reset();
        test_tx_fifo();
        test_rx();
        test_stream_clr();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
